// File: rtl/i2c_temp_responder_if.sv
// Pad-side I2C signals of the temperature responder.
// SDA is open-drain: the responder only ever pulls it low.
interface i2c_temp_responder_if;
  logic scl_i;
  logic sda_i;
  logic sda_drive_low;

  modport master (
    output scl_i,
    output sda_i,
    input  sda_drive_low
  );

  modport slave (
    input  scl_i,
    input  sda_i,
    output sda_drive_low
  );
endinterface

// File: rtl/i2c_temp_responder.sv
// ADT7420-style I2C responder serving a 13-bit temperature word.
// Bus lines are oversampled and filtered inside the clk domain.
module i2c_temp_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h4B,
  parameter int         FILTER_LEN = 3,
  parameter logic [7:0] ID_VALUE   = 8'hCB
) (
  input  logic                 clk,
  input  logic                 reset,
  i2c_temp_responder_if.slave  bus,
  input  logic [12:0]          temp_in,
  output logic [7:0]           config_o,
  output logic                 busy,
  output logic                 rd_done
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE,
    WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  localparam int RW = $clog2(FILTER_LEN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(FILTER_LEN - 1);

  state_t state, state_n;

  logic [1:0]  raw, s1, s2, filt;
  logic        scl, sda, scl_q, sda_q;
  logic        scl_rise, scl_fall;
  logic        start_ev, stop_ev;
  logic [3:0]  cnt;
  logic [7:0]  rx, tx, pointer, rd_byte;
  logic [15:0] snapshot;
  logic        first_wr, ack_seen;
  logic        byte_done, addr_hit;

  assign raw = {bus.sda_i, bus.scl_i};

  // Two-flop synchronizer, preset to the idle-bus level.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 2'b11;
      s2 <= 2'b11;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_flt
    logic [RW-1:0] run;
    logic          lvl;
    assign filt[g] = lvl;
    // Adopt a new level after FILTER_LEN identical samples.
    always_ff @(posedge clk) begin
      if (reset) begin
        run <= '0;
        lvl <= 1'b1;
      end else if (s2[g] == lvl) begin
        run <= '0;
      end else if (run == RUN_MAX) begin
        run <= '0;
        lvl <= s2[g];
      end else begin
        run <= run + RW'(1);
      end
    end
  end

  assign scl = filt[0];
  assign sda = filt[1];

  // Previous filtered levels for edge and condition detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_ev  = scl & scl_q & sda_q & ~sda;
  assign stop_ev   = scl & scl_q & ~sda_q & sda;
  assign byte_done = (cnt == 4'd8);
  assign addr_hit  = (rx[7:1] == DEV_ADDR);

  // Read-side register map.
  always_comb begin
    rd_byte = 8'h00;
    unique case (1'b1)
      pointer == 8'h00: rd_byte = snapshot[15:8];
      pointer == 8'h01: rd_byte = snapshot[7:0];
      pointer == 8'h03: rd_byte = config_o;
      pointer == 8'h0B: rd_byte = ID_VALUE;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; STOP and START win in every state.
  always_comb begin
    state_n = state;
    if (stop_ev) begin
      state_n = IDLE;
    end else if (start_ev) begin
      state_n = ADDR;
    end else begin
      unique case (state)
        ADDR:
          if (scl_fall && byte_done)
            state_n = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:
          if (scl_fall)
            state_n = rx[0] ? RD_BYTE : WR_BYTE;
        WR_BYTE:
          if (scl_fall && byte_done) state_n = WR_ACK;
        WR_ACK:
          if (scl_fall) state_n = WR_BYTE;
        RD_BYTE:
          if (scl_fall && cnt == 4'd7) state_n = RD_ACK;
        RD_ACK:
          if (scl_rise && sda) state_n = WAIT_STOP;
          else if (scl_fall && ack_seen) state_n = RD_BYTE;
        default: state_n = state;
      endcase
    end
  end

  // Datapath: shifters, pointer, CONFIG and snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= 4'd0;
      rx       <= 8'h00;
      tx       <= 8'h00;
      pointer  <= 8'h00;
      config_o <= 8'h00;
      snapshot <= 16'h0000;
      first_wr <= 1'b0;
      ack_seen <= 1'b0;
      rd_done  <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (start_ev) begin
        cnt <= 4'd0;
      end else if (!stop_ev) begin
        unique case (state)
          ADDR, WR_BYTE: begin
            if (scl_rise && !byte_done) begin
              rx  <= {rx[6:0], sda};
              cnt <= cnt + 4'd1;
            end
            if (scl_fall && byte_done) begin
              cnt <= 4'd0;
              if (state == ADDR) begin
                first_wr <= 1'b1;
                if (addr_hit && rx[0])
                  snapshot <= {temp_in, 3'b000};
              end else begin
                first_wr <= 1'b0;
                if (first_wr) begin
                  pointer <= rx;
                end else begin
                  if (pointer == 8'h03) config_o <= rx;
                  pointer <= pointer + 8'd1;
                end
              end
            end
          end
          ADDR_ACK:
            if (scl_fall) begin
              cnt <= 4'd0;
              tx  <= rd_byte;
            end
          RD_BYTE:
            if (scl_fall) begin
              if (cnt == 4'd7) begin
                ack_seen <= 1'b0;
              end else begin
                tx  <= {tx[6:0], 1'b0};
                cnt <= cnt + 4'd1;
              end
            end
          RD_ACK: begin
            if (scl_rise) begin
              ack_seen <= ~sda;
              pointer  <= pointer + 8'd1;
              rd_done  <= (pointer == 8'h01);
            end
            if (scl_fall && ack_seen) begin
              tx  <= rd_byte;
              cnt <= 4'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs: SDA pull-low enable and busy flag.
  always_comb begin
    bus.sda_drive_low = 1'b0;
    unique case (state)
      ADDR_ACK, WR_ACK: bus.sda_drive_low = 1'b1;
      RD_BYTE:          bus.sda_drive_low = ~tx[7];
      default:          bus.sda_drive_low = 1'b0;
    endcase
    busy = (state != IDLE);
  end

endmodule
